// File: rtl/rd_writeback_buffer_if.sv
// rd_writeback_buffer_if: result-input, register-file write and hazard-probe bundle
interface rd_writeback_buffer_if #(parameter int N = 16, parameter int A = 4, parameter int DEPTH = 4);
    logic [3:0]              op_code;
    logic [A-1:0]            rd_addr;
    logic [N-1:0]            res_in;
    logic                    in_valid;
    logic                    in_ready;
    logic                    wr_en;
    logic [A-1:0]            wr_addr;
    logic [N-1:0]            wr_data;
    logic                    wr_ready;
    logic [A-1:0]            rs_query;
    logic                    pend_hit;
    logic [$clog2(DEPTH):0]  level;
    logic [15:0]             wb_count;
    modport master (
        output op_code, rd_addr, res_in, in_valid, wr_ready, rs_query,
        input  in_ready, wr_en, wr_addr, wr_data, pend_hit, level, wb_count
    );
    modport slave (
        input  op_code, rd_addr, res_in, in_valid, wr_ready, rs_query,
        output in_ready, wr_en, wr_addr, wr_data, pend_hit, level, wb_count
    );
endinterface

// File: rtl/rd_writeback_buffer.sv
// rd_writeback_buffer: in-order FIFO of register-writing ALU results feeding the register-file write port
module rd_writeback_buffer #(parameter int N = 16, parameter int A = 4, parameter int DEPTH = 4) (
    input  logic                  clk,
    input  logic                  rst,
    rd_writeback_buffer_if.slave  bus
);
    localparam int P = $clog2(DEPTH);
    logic [A-1:0]     r_addr [DEPTH];
    logic [N-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [P-1:0]     r_wp;
    logic [P-1:0]     r_rp;
    logic [P:0]       r_level;
    logic [15:0]      r_wb_count;
    logic             w_push;
    logic             w_pop;
    logic             w_hit;
    assign bus.in_ready = r_level != (P+1)'(DEPTH);
    assign bus.wr_en    = r_level != '0;
    // non-writing ops are still handshaken so the producer never stalls on them
    assign w_push       = bus.in_valid && bus.in_ready && bus.op_code[3:2] == 2'b00;
    assign w_pop        = bus.wr_en && bus.wr_ready;
    assign bus.wr_addr  = bus.wr_en ? r_addr[r_rp] : '0;
    assign bus.wr_data  = bus.wr_en ? r_data[r_rp] : '0;
    assign bus.pend_hit = w_hit;
    assign bus.level    = r_level;
    assign bus.wb_count = r_wb_count;
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) w_hit = w_hit | (r_vld[i] && r_addr[i] == bus.rs_query);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_wb_count <= '0;
            r_vld      <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_wp] <= bus.rd_addr;
                r_data[r_wp] <= bus.res_in;
                r_wp         <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp       <= r_rp + 1'b1;
                r_wb_count <= r_wb_count + 16'd1;
            end
            r_vld   <= (r_vld & ~(DEPTH'(w_pop) << r_rp)) | (DEPTH'(w_push) << r_wp);
            r_level <= r_level + (P+1)'(w_push) - (P+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_rd_writeback_buffer.sv
// tb_rd_writeback_buffer: directed vector table plus hand sequences for stall, wrap and flush cases
module tb_rd_writeback_buffer;
    localparam int N = 16, A = 4, DEPTH = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    rd_writeback_buffer_if #(.N(N), .A(A), .DEPTH(DEPTH)) bus();
    rd_writeback_buffer #(.N(N), .A(A), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic rst, iv; logic [3:0] op, rd; logic [15:0] res; logic wrr; logic [3:0] rsq;
        logic ir, we; logic [3:0] wa; logic [15:0] wd; logic ph; logic [2:0] lv; logic [15:0] wbc;
    } vec_t;
    vec_t tbl[13];
    int checks = 0, failures = 0;

    function automatic vec_t mk(int r, int iv, int op, int rd, int res, int wrr, int rsq,
                                int ir, int we, int wa, int wd, int ph, int lv, int wbc);
        vec_t v;
        v.rst = 1'(r); v.iv = 1'(iv); v.op = 4'(op); v.rd = 4'(rd); v.res = 16'(res);
        v.wrr = 1'(wrr); v.rsq = 4'(rsq); v.ir = 1'(ir); v.we = 1'(we); v.wa = 4'(wa);
        v.wd = 16'(wd); v.ph = 1'(ph); v.lv = 3'(lv); v.wbc = 16'(wbc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic drive(input int r, input int iv, input int op, input int rd, input int res,
                         input int wrr, input int rsq);
        rst = 1'(r); bus.in_valid = 1'(iv); bus.op_code = 4'(op); bus.rd_addr = 4'(rd);
        bus.res_in = 16'(res); bus.wr_ready = 1'(wrr); bus.rs_query = 4'(rsq);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string nm, input int we, input int wa, input int wd, input int lv);
        chk({nm, "_wr_en"}, 32'(bus.wr_en), 32'(we));
        chk({nm, "_wr_addr"}, 32'(bus.wr_addr), 32'(wa));
        chk({nm, "_wr_data"}, 32'(bus.wr_data), 32'(wd));
        chk({nm, "_level"}, 32'(bus.level), 32'(lv));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea[5], ed[5], el[5];
        //            rst iv op  rd res     wrr rsq | ir we wa wd      ph lv wbc
        tbl[0]  = mk(1,  0, 0,  0, 0,      1,  0,    1, 0, 0, 0,      0, 0, 0);
        tbl[1]  = mk(0,  0, 0,  0, 0,      1,  0,    1, 0, 0, 0,      0, 0, 0);
        tbl[2]  = mk(0,  1, 1,  3, 'h00A5, 1,  3,    1, 1, 3, 'h00A5, 1, 1, 0);
        tbl[3]  = mk(0,  0, 0,  0, 0,      1,  3,    1, 0, 0, 0,      0, 0, 1);
        tbl[4]  = mk(0,  1, 5,  7, 'h1234, 1,  7,    1, 0, 0, 0,      0, 0, 1);
        tbl[5]  = mk(0,  1, 4,  7, 'h1234, 1,  7,    1, 0, 0, 0,      0, 0, 1);
        tbl[6]  = mk(0,  1, 15, 7, 'h1234, 1,  7,    1, 0, 0, 0,      0, 0, 1);
        tbl[7]  = mk(0,  1, 3,  7, 'h1234, 0,  7,    1, 1, 7, 'h1234, 1, 1, 1);
        tbl[8]  = mk(0,  1, 0,  5, 1,      0,  5,    1, 1, 7, 'h1234, 1, 2, 1);
        tbl[9]  = mk(0,  1, 2,  5, 2,      0,  6,    1, 1, 7, 'h1234, 0, 3, 1);
        tbl[10] = mk(0,  0, 0,  0, 0,      1,  5,    1, 1, 5, 1,      1, 2, 2);
        tbl[11] = mk(0,  0, 0,  0, 0,      1,  5,    1, 1, 5, 2,      1, 1, 3);
        tbl[12] = mk(0,  0, 0,  0, 0,      1,  5,    1, 0, 0, 0,      0, 0, 4);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].op, tbl[i].rd, tbl[i].res, tbl[i].wrr, tbl[i].rsq);
            tick();
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].ir));
            chk($sformatf("v%0d_wr_en", i), 32'(bus.wr_en), 32'(tbl[i].we));
            chk($sformatf("v%0d_wr_addr", i), 32'(bus.wr_addr), 32'(tbl[i].wa));
            chk($sformatf("v%0d_wr_data", i), 32'(bus.wr_data), 32'(tbl[i].wd));
            chk($sformatf("v%0d_pend_hit", i), 32'(bus.pend_hit), 32'(tbl[i].ph));
            chk($sformatf("v%0d_level", i), 32'(bus.level), 32'(tbl[i].lv));
            chk($sformatf("v%0d_wb_count", i), 32'(bus.wb_count), 32'(tbl[i].wbc));
        end

        // stall to FULL, hold a fifth input, then drain in order
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 1, k, k * 'h10, 0, 0);
            tick();
        end
        drive(0, 1, 1, 9, 'h50, 0, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            head($sformatf("full_hold%0d", k), 1, 1, 'h10, 4);
            chk($sformatf("full_hold%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
        end
        ea = '{1, 2, 3, 4, 9};
        ed = '{'h10, 'h20, 'h30, 'h40, 'h50};
        el = '{4, 3, 3, 2, 1};
        bus.wr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.rs_query = 4'(ea[k]);
            #1;
            head($sformatf("drain%0d", k), 1, ea[k], ed[k], el[k]);
            chk($sformatf("drain%0d_pend_hit", k), 32'(bus.pend_hit), 32'd1);
            if (k == 0) chk("drain0_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
            if (k == 1) bus.in_valid = 1'b0;
        end
        head("drained", 0, 0, 0, 0);
        chk("drained_wb_count", 32'(bus.wb_count), 32'd9);

        // steady push+pop at level 2 across pointer wrap
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 2, 8 + k, 'h100 + k, 0, 0);
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            drive(0, 1, 2, 8 + j + 2, 'h100 + j + 2, 1, 0);
            tick();
            head($sformatf("pp%0d", j), 1, 8 + j + 1, 'h100 + j + 1, 2);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        head("pp_tail0", 1, 14, 'h106, 2);
        tick();
        head("pp_tail1", 1, 15, 'h107, 1);
        tick();
        head("pp_done", 0, 0, 0, 0);
        chk("pp_wb_count", 32'(bus.wb_count), 32'd17);

        // reset while FULL flushes everything, inputs in the reset cycle ignored
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 0, k, 'hDEA0 + k, 0, 1);
            tick();
        end
        chk("pre_flush_level", 32'(bus.level), 32'd4);
        drive(1, 1, 0, 1, 'hBEEF, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        #1;
        head("flush", 0, 0, 0, 0);
        chk("flush_pend_hit", 32'(bus.pend_hit), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_wb_count", 32'(bus.wb_count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("flush_idle%0d_wr_en", k), 32'(bus.wr_en), 32'd0);
            chk($sformatf("flush_idle%0d_wb_count", k), 32'(bus.wb_count), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rd_writeback_buffer.md
Name: rd_writeback_buffer

Overview:
- Result-side counterpart of the rs2 operand path: takes ALU results tagged with op_code and destination register, and drives the register-file write port.
- Only the register-writing ops (op_code 4'b0000..4'b0011) are retained. All other op_codes are consumed and dropped.
- A small in-order FIFO absorbs register-file write stalls.
- A pending-hit output lets the operand path detect read-after-write hazards against results still queued.

Parameters:
- N, 16, data width of ALU result and register-file write data.
- A, 4, register address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- op_code  input  4  opcode of the incoming result
- rd_addr  input  A  destination register of the incoming result
- res_in  input  N  ALU result
- in_valid  input  1  incoming result valid
- in_ready  output  1  buffer can accept this cycle
- wr_en  output  1  register-file write request (head entry valid)
- wr_addr  output  A  write address (head entry)
- wr_data  output  N  write data (head entry)
- wr_ready  input  1  register file accepts the write this cycle
- rs_query  input  A  register address probed for hazard
- pend_hit  output  1  rs_query matches a queued entry
- level  output  $clog2(DEPTH)+1  number of queued entries
- wb_count  output  16  total writes retired, wraps modulo 2^16

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - Read/write pointers, level and wb_count clear to 0; all entries invalid.
  - In the following cycle: wr_en=0, wr_addr=0, wr_data=0, pend_hit=0, in_ready=1.
- Reset mid-operation flushes all queued entries.
  - No write is issued for flushed entries.
  - Inputs presented in the reset cycle are ignored.
- FIFO states, derived from level: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- in_ready = (level != DEPTH). It depends only on registered state, never on wr_ready.
- Accept = in_valid & in_ready.
  - If op_code is in 0000..0011: push {rd_addr, res_in} at the tail.
  - Otherwise: the transfer completes, nothing is stored, level is unchanged.
  - When in_ready=0, the input holds; nothing is consumed.
- Write port is first-word-fall-through:
  - wr_en = (level != 0); wr_addr/wr_data show the head entry.
  - When EMPTY, wr_addr and wr_data are driven to 0.
- Pop = wr_en & wr_ready: advance head, wb_count += 1.
- Latency: a result accepted at edge k presents wr_en=1 in the cycle after edge k, if the FIFO was empty. There is no combinational input-to-write bypass.
- Simultaneous push and pop in the same cycle: level unchanged, both pointers advance.
  - Legal in every state except FULL, where no push occurs because in_ready=0.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH or underflows.
- Ordering: writes issue in strict acceptance order. Multiple entries to the same rd are all written, oldest first.
- Outputs hold while wr_en=1 and wr_ready=0: wr_addr/wr_data are stable until pop.
- pend_hit: combinational OR over valid entries of (entry_addr == rs_query).
  - The entry being popped this cycle still counts.
  - The incoming, not-yet-accepted input does not count.
- wb_count is 16 bits, wrapping FFFF->0000 on pop.

Test Plan:
1. Reset then idle -> wr_en=0, level=0, in_ready=1, wb_count=0; then one accept of op=0001, rd=3, res=16'h00A5 with wr_ready=1 -> next cycle wr_en=1, wr_addr=3, wr_data=00A5; following cycle wr_en=0, wb_count=1.
2. op=0101, rd=7, res=1234, in_valid=1 -> in_ready=1, level stays 0, wr_en never rises, pend_hit with rs_query=7 stays 0.
3. wr_ready=0, push 4 writes rd=1..4 data 10..40 -> level=4, in_ready=0, a 5th input held; raise wr_ready -> writes issue 1,2,3,4 in order with data 10,20,30,40; the 5th is accepted once in_ready=1.
4. Level=2, drive push and pop in the same cycle for 6 cycles -> level stays 2, order preserved across pointer wrap.
5. Queue rd=5 and rd=5 (data 1, then 2), rs_query=5 -> pend_hit=1 until the second pop; register file sees 1 then 2; rs_query=6 -> pend_hit=0.
6. FULL with wr_ready=0, assert rst for one edge -> next cycle level=0, wr_en=0, pend_hit=0, wb_count=0; no flushed entry is ever written.
